gobang_win_scanner: RTL and testbench

- Consumer side of the board datapath's strategy/checker window interface.
- On a start request it sweeps every board cell in row-major order, one cell per clock. For each cell it drives the consider coordinates and receives the eight 9-cell line windows back combinationally.
- It reports the first five-in-a-row found, or a draw when the board is full with no winner.
- It sits between the game-control FSM and the board datapath, and replaces ad-hoc win checks in the logic block.

---
 rtl/gobang_pkg.sv | 14 +
 rtl/gobang_five_detect.sv | 7 +
 rtl/gobang_win_scanner.sv | 103 ++++++++++
 tb/tb_gobang_win_scanner.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/gobang_pkg.sv
// gobang_pkg: shared board constants, result/direction codes and scanner state encoding.
package gobang_pkg;
  localparam int BOARD_SIZE = 15;
  localparam int CELL_COUNT = BOARD_SIZE * BOARD_SIZE;
  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_BLACK = 2'd1;
  localparam logic [1:0] RES_WHITE = 2'd2;
  localparam logic [1:0] RES_DRAW  = 2'd3;
  localparam logic [1:0] DIR_ROW  = 2'd0;
  localparam logic [1:0] DIR_COL  = 2'd1;
  localparam logic [1:0] DIR_DIAG = 2'd2;
  localparam logic [1:0] DIR_ANTI = 2'd3;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
endpackage

// File: rtl/gobang_five_detect.sv
// gobang_five_detect: flags five or more consecutive stones through the centre of a 9-cell window.
module gobang_five_detect (
  input  logic [8:0] win_i,
  output logic       hit_o
);
  assign hit_o = (&win_i[4:0]) | (&win_i[5:1]) | (&win_i[6:2]) | (&win_i[7:3]) | (&win_i[8:4]);
endmodule

// File: rtl/gobang_win_scanner.sv
// gobang_win_scanner: sweeps the board one cell per clock and reports the first five-in-a-row or a draw.
module gobang_win_scanner
  import gobang_pkg::*;
#(
  parameter int BOARD_SIZE  = 15,
  parameter bit STOP_ON_WIN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] consider_i,
  output logic [3:0] consider_j,
  input  logic [8:0] black_i,
  input  logic [8:0] black_j,
  input  logic [8:0] black_ij,
  input  logic [8:0] black_ji,
  input  logic [8:0] white_i,
  input  logic [8:0] white_j,
  input  logic [8:0] white_ij,
  input  logic [8:0] white_ji,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic [3:0] win_i,
  output logic [3:0] win_j,
  output logic [1:0] win_dir
);
  localparam logic [7:0] CELLS = 8'(BOARD_SIZE * BOARD_SIZE);
  localparam logic [3:0] LAST  = 4'(BOARD_SIZE - 1);
  state_e          state_q;
  logic [3:0]      ci_q, cj_q, wi_q, wj_q;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      res_q, dir_q, hit_res, hit_dir;
  logic [7:0][8:0] wins;
  logic [7:0]      hits;
  logic            last_cell, record;
  // Index order encodes priority: black before white, then row/col/diag/anti.
  assign wins = {white_ji, white_ij, white_j, white_i, black_ji, black_ij, black_j, black_i};
  for (genvar g = 0; g < 8; g++) begin : g_det
    gobang_five_detect u_det (.win_i(wins[g]), .hit_o(hits[g]));
  end
  always_comb begin
    hit_res = RES_NONE;
    hit_dir = DIR_ROW;
    for (int k = 7; k >= 0; k--) begin
      if (hits[k]) begin
        hit_res = k < 4 ? RES_BLACK : RES_WHITE;
        hit_dir = 2'(k);
      end
    end
    cnt_d     = cnt_q + 8'(black_i[4] | white_i[4]);
    last_cell = ci_q == LAST && cj_q == LAST;
    record    = |hits && res_q == RES_NONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ci_q    <= '0;
      cj_q    <= '0;
      cnt_q   <= '0;
      res_q   <= RES_NONE;
      wi_q    <= '0;
      wj_q    <= '0;
      dir_q   <= DIR_ROW;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= SCAN;
          ci_q    <= '0;
          cj_q    <= '0;
          cnt_q   <= '0;
          res_q   <= RES_NONE;
          wi_q    <= '0;
          wj_q    <= '0;
          dir_q   <= DIR_ROW;
        end
        SCAN: begin
          cnt_q <= cnt_d;
          cj_q  <= cj_q == LAST ? 4'd0 : cj_q + 4'd1;
          if (cj_q == LAST) ci_q <= ci_q + 4'd1;
          if (record) begin
            res_q <= hit_res;
            wi_q  <= ci_q;
            wj_q  <= cj_q;
            dir_q <= hit_dir;
          end else if (last_cell && res_q == RES_NONE && cnt_d == CELLS) begin
            res_q <= RES_DRAW;
          end
          if ((record && STOP_ON_WIN) || last_cell) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign consider_i = ci_q;
  assign consider_j = cj_q;
  assign busy       = state_q == SCAN;
  assign done       = state_q == DONE;
  assign result     = res_q;
  assign win_i      = wi_q;
  assign win_j      = wj_q;
  assign win_dir    = dir_q;
endmodule

// File: tb/tb_gobang_win_scanner.sv
// tb_gobang_win_scanner: board model drives windows; directed scans queue expectations, a monitor checks each done pulse.
module tb_gobang_win_scanner;
  logic       clk = 0, rst = 1, start = 0;
  logic [3:0] ci, cj, wi, wj;
  logic [8:0] bi, bj, bij, bji, whi, whj, whij, whji;
  logic       busy, done;
  logic [1:0] result, wdir;
  bit         bb [15][15];
  bit         wb [15][15];
  typedef struct {int res; int wi; int wj; int dir; int lat;} exp_t;
  exp_t q[$];
  int nvec = 0, nbad = 0, cyc = 0, t0 = 0, bcnt = 0, pops = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gobang_win_scanner dut (
    .clk(clk), .rst(rst), .start(start), .consider_i(ci), .consider_j(cj),
    .black_i(bi), .black_j(bj), .black_ij(bij), .black_ji(bji),
    .white_i(whi), .white_j(whj), .white_ij(whij), .white_ji(whji),
    .busy(busy), .done(done), .result(result), .win_i(wi), .win_j(wj), .win_dir(wdir)
  );

  function automatic bit at(bit w, int r, int c);
    if (r < 0 || r > 14 || c < 0 || c > 14) return 1'b0;
    return w ? wb[r][c] : bb[r][c];
  endfunction

  always_comb begin
    bi = '0; bj = '0; bij = '0; bji = '0; whi = '0; whj = '0; whij = '0; whji = '0;
    for (int k = 0; k < 9; k++) begin
      bi[k]   = at(1'b0, int'(ci), int'(cj) + k - 4);
      bj[k]   = at(1'b0, int'(ci) + k - 4, int'(cj));
      bij[k]  = at(1'b0, int'(ci) + k - 4, int'(cj) + k - 4);
      bji[k]  = at(1'b0, int'(ci) + k - 4, int'(cj) - k + 4);
      whi[k]  = at(1'b1, int'(ci), int'(cj) + k - 4);
      whj[k]  = at(1'b1, int'(ci) + k - 4, int'(cj));
      whij[k] = at(1'b1, int'(ci) + k - 4, int'(cj) + k - 4);
      whji[k] = at(1'b1, int'(ci) + k - 4, int'(cj) - k + 4);
    end
  end

  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && start && !busy && !done) begin
      t0 = cyc;
      bcnt = 0;
    end else if (busy) bcnt++;
    if (rst && done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'(result), e.res);
        chk("win_i", int'(wi), e.wi);
        chk("win_j", int'(wj), e.wj);
        chk("win_dir", int'(wdir), e.dir);
        chk("latency", cyc - t0 - 1, e.lat);
        chk("busy_cycles", bcnt, e.lat);
        pops++;
      end
    end
  end

  task automatic clear();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) begin
        bb[r][c] = 1'b0;
        wb[r][c] = 1'b0;
      end
  endtask

  task automatic line(bit w, int r, int c, int dr, int dc, int n);
    for (int k = 0; k < n; k++)
      if (w) wb[r + k*dr][c + k*dc] = 1'b1;
      else bb[r + k*dr][c + k*dc] = 1'b1;
  endtask

  task automatic run(int res, int ewi, int ewj, int dir, int lat, int restart_at, bit hold);
    exp_t e;
    int p;
    e = '{res: res, wi: ewi, wj: ewj, dir: dir, lat: lat};
    q.push_back(e);
    p = pops;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("busy_after_start", int'(busy), 1);
    for (int n = 0; n < 400 && pops == p; n++) begin
      @(posedge clk); #1;
      start = (n == restart_at) || (hold && done);
    end
    if (pops == p) chk("done_timeout", 0, 1);
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
  endtask

  initial begin
    #2 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_win_i", int'(wi), 0);
    chk("rst_win_j", int'(wj), 0);
    chk("rst_win_dir", int'(wdir), 0);
    chk("rst_ci", int'(ci), 0);
    chk("rst_cj", int'(cj), 0);
    rst = 1;
    clear(); run(0, 0, 0, 0, 225, -1, 0);
    clear(); line(0, 7, 3, 0, 1, 5); run(1, 7, 3, 0, 109, 20, 0);
    clear(); line(1, 2, 5, 1, 0, 5); run(2, 2, 5, 1, 36, -1, 1);
    clear(); line(0, 6, 2, -1, 1, 5); run(1, 2, 6, 3, 37, -1, 0);
    clear(); line(0, 7, 3, 0, 1, 4); run(0, 0, 0, 0, 225, -1, 0);
    clear(); line(0, 3, 3, 1, 1, 5); run(1, 3, 3, 2, 49, -1, 0);
    clear(); line(0, 5, 5, 0, 1, 5); line(0, 5, 5, 1, 0, 5); run(1, 5, 5, 0, 81, -1, 0);
    clear(); line(1, 1, 10, 0, 1, 5); line(0, 3, 0, 0, 1, 5); run(2, 1, 10, 0, 26, -1, 0);
    clear(); line(0, 0, 0, 0, 1, 6); run(1, 0, 0, 0, 1, -1, 0);
    clear(); line(1, 10, 14, 1, 0, 5); run(2, 10, 14, 1, 165, -1, 0);
    clear();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        if (((r + (c >> 1)) % 2) == 1) wb[r][c] = 1'b1;
        else bb[r][c] = 1'b1;
    run(3, 0, 0, 0, 225, -1, 0);
    clear();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (50) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ci", int'(ci), 0);
    chk("midrst_cj", int'(cj), 0);
    chk("midrst_result", int'(result), 0);
    @(posedge clk); #1 rst = 1;
    repeat (300) @(posedge clk);
    #1 chk("midrst_still_idle", int'(busy), 0);
    line(0, 7, 3, 0, 1, 5); run(1, 7, 3, 0, 109, -1, 0);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
